// File: rtl/transformer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | transformer_pkg                                                      |
// | Instance transform type: 3x4 fixed-point matrix, row-major.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package transformer_pkg;

  typedef struct packed {
    logic [11:0][15:0] m;
  } transform_t;

endpackage
`default_nettype wire

// File: rtl/tri_lane_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tri_lane_dispatch_pkg                                                |
// | Shared helpers for the multi-lane transform dispatcher.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tri_lane_dispatch_pkg;

  // Pointer width that stays at least one bit for a single-lane build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vertex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vertex_pkg                                                           |
// | Vertex and triangle types shared across the geometry pipeline.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vertex_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t v2;
    vertex_t v1;
    vertex_t v0;
  } triangle_t;

endpackage
`default_nettype wire

// File: rtl/tri_lane_dispatch_lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_fifo                                                            |
// | Synchronous FIFO, async reset, fall-through head, full/empty flags.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w:0] r_wr;
  logic [c_addr_w:0] r_rd;
  logic              w_push;
  logic              w_pop;

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign empty  = (r_wr == r_rd);
  assign full   = (r_wr[c_addr_w] != r_rd[c_addr_w]) &&
                  (r_wr[c_addr_w-1:0] == r_rd[c_addr_w-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd[c_addr_w-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[c_addr_w-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tri_lane_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tri_lane_dispatch                                                    |
// | Round-robin issue of triangles to N transformer lanes, in-order      |
// | credit-limited re-merge with frame-end marking.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tri_lane_dispatch
  import vertex_pkg::*;
  import transformer_pkg::*;
  import tri_lane_dispatch_pkg::*;
#(
  parameter int N_LANES    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LANE_W     = ptr_width(N_LANES),
  parameter int CRED_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  triangle_t          in_triangle,
  input  transform_t         in_transform,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output triangle_t          lane_triangle  [N_LANES],
  output transform_t         lane_transform [N_LANES],
  output logic [N_LANES-1:0] lane_valid,
  input  logic [N_LANES-1:0] lane_ready,
  input  triangle_t          lane_result    [N_LANES],
  input  logic [N_LANES-1:0] lane_result_valid,
  output logic [N_LANES-1:0] lane_result_ready,
  output triangle_t          out_triangle,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [CRED_W-1:0] c_full_credit = CRED_W'(FIFO_DEPTH);
  localparam logic [LANE_W-1:0] c_last_lane   = LANE_W'(N_LANES - 1);

  logic [LANE_W-1:0]  r_dp;
  logic [LANE_W-1:0]  r_cp;
  logic [CRED_W-1:0]  r_credit     [N_LANES];
  logic [CRED_W-1:0]  w_credit_nxt [N_LANES];
  triangle_t          w_res_head   [N_LANES];
  logic [N_LANES-1:0] w_res_full;
  logic [N_LANES-1:0] w_res_empty;
  logic [N_LANES-1:0] w_res_push;
  logic [N_LANES-1:0] w_tag_head;
  logic [N_LANES-1:0] w_tag_full;
  logic [N_LANES-1:0] w_tag_empty;
  logic [N_LANES-1:0] w_dispatch;
  logic [N_LANES-1:0] w_collect;
  logic [N_LANES-1:0] w_lane_busy;
  logic               w_room;
  logic               w_accept;
  logic               w_pop;
  logic               r_frame_done;
  logic               r_busy;

  assign w_room     = (r_credit[r_dp] < c_full_credit) && !w_tag_full[r_dp];
  assign in_ready   = lane_ready[r_dp] && w_room;
  assign w_accept   = in_valid && in_ready;

  assign out_valid    = !w_res_empty[r_cp];
  assign out_triangle = w_res_head[r_cp];
  assign out_last     = out_valid && !w_tag_empty[r_cp] && w_tag_head[r_cp];
  assign w_pop        = out_valid && out_ready;

  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    localparam logic [LANE_W-1:0] c_lane = LANE_W'(k);

    assign lane_triangle[k]     = in_triangle;
    assign lane_transform[k]    = in_transform;
    assign lane_valid[k]        = (r_dp == c_lane) && in_valid && w_room;
    assign w_dispatch[k]        = (r_dp == c_lane) && w_accept;
    assign w_collect[k]         = (r_cp == c_lane) && w_pop;
    assign lane_result_ready[k] = !w_res_full[k];
    assign w_res_push[k]        = lane_result_valid[k] && !w_res_full[k];

    // Same-cycle dispatch and pop on one lane cancel out.
    assign w_credit_nxt[k] = r_credit[k] + CRED_W'(w_dispatch[k]) - CRED_W'(w_collect[k]);
    assign w_lane_busy[k]  = |w_credit_nxt[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_credit[k] <= '0;
      else     r_credit[k] <= w_credit_nxt[k];
    end

    lane_fifo #(.WIDTH($bits(triangle_t)), .DEPTH(FIFO_DEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_res_push[k]),
      .din   (lane_result[k]),
      .pop   (w_collect[k]),
      .dout  (w_res_head[k]),
      .full  (w_res_full[k]),
      .empty (w_res_empty[k])
    );

    lane_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_dispatch[k]),
      .din   (in_last),
      .pop   (w_collect[k]),
      .dout  (w_tag_head[k]),
      .full  (w_tag_full[k]),
      .empty (w_tag_empty[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp         <= '0;
      r_cp         <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_accept) r_dp <= (r_dp == c_last_lane) ? '0 : r_dp + LANE_W'(1);
      if (w_pop)    r_cp <= (r_cp == c_last_lane) ? '0 : r_cp + LANE_W'(1);
      r_frame_done <= w_pop && out_last;
      r_busy       <= |w_lane_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_lane_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tri_lane_dispatch                                                 |
// | Directed bench: latency-programmable lane models, output scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tri_lane_dispatch;
  import vertex_pkg::*;
  import transformer_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  triangle_t    in_triangle;
  transform_t   in_transform;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  triangle_t    lane_triangle  [N];
  transform_t   lane_transform [N];
  logic [N-1:0] lane_valid;
  logic [N-1:0] lane_ready;
  triangle_t    lane_result    [N];
  logic [N-1:0] lane_result_valid;
  logic [N-1:0] lane_result_ready;
  triangle_t    out_triangle;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         frame_done;
  logic         busy;

  always #5 clk = ~clk;

  tri_lane_dispatch #(.N_LANES(N), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_triangle       (in_triangle),
    .in_transform      (in_transform),
    .in_last           (in_last),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .lane_triangle     (lane_triangle),
    .lane_transform    (lane_transform),
    .lane_valid        (lane_valid),
    .lane_ready        (lane_ready),
    .lane_result       (lane_result),
    .lane_result_valid (lane_result_valid),
    .lane_result_ready (lane_result_ready),
    .out_triangle      (out_triangle),
    .out_last          (out_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .frame_done        (frame_done),
    .busy              (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { triangle_t t; int rdy; } lane_item_t;
  typedef struct { triangle_t t; logic last; } in_item_t;

  lane_item_t lq0[$];
  lane_item_t lq1[$];
  in_item_t   send_q[$];
  int         exp_tag_q[$];
  bit         exp_last_q[$];
  int         lane_log[$];
  int         lat [N];
  int         cyc = 0;
  int         accepted = 0;
  int         fd_count = 0;
  int         gap = 0;
  bit         seen_out = 0;
  bit         fd_exp = 0;

  function automatic triangle_t xform(input triangle_t t);
    triangle_t r;
    r = t;
    r.v0.x = t.v0.x + 16'sd1000;
    return r;
  endfunction

  // Lane models: fixed per-lane latency, strictly in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lq0.delete();
      lq1.delete();
      lane_result_valid = '0;
    end else begin
      if (lane_result_valid[0] && lane_result_ready[0]) void'(lq0.pop_front());
      if (lane_result_valid[1] && lane_result_ready[1]) void'(lq1.pop_front());
      if (lane_valid[0] && lane_ready[0]) begin
        lq0.push_back('{t: lane_triangle[0], rdy: cyc + lat[0]});
        lane_log.push_back(0);
      end
      if (lane_valid[1] && lane_ready[1]) begin
        lq1.push_back('{t: lane_triangle[1], rdy: cyc + lat[1]});
        lane_log.push_back(1);
      end
      cyc++;
      #1;
      lane_result_valid[0] = (lq0.size() > 0) && (cyc >= lq0[0].rdy);
      lane_result_valid[1] = (lq1.size() > 0) && (cyc >= lq1[0].rdy);
      if (lq0.size() > 0) lane_result[0] = xform(lq0[0].t);
      if (lq1.size() > 0) lane_result[1] = xform(lq1[0].t);
    end
  end

  // Input driver
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        void'(send_q.pop_front());
        accepted++;
      end
      #1;
      if (send_q.size() > 0) begin
        in_valid    = 1'b1;
        in_triangle = send_q[0].t;
        in_last     = send_q[0].last;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Output scoreboard and frame_done timing
  always @(negedge clk) begin
    if (rst) begin
      fd_exp = 1'b0;
    end else begin
      if (fd_exp || frame_done) check("frame_done", frame_done, fd_exp);
      if (frame_done) fd_count++;
      fd_exp = 1'b0;
      if (!out_valid && exp_tag_q.size() > 0 && seen_out) gap++;
      if (out_valid && out_ready) begin
        if (exp_tag_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_tri_x", out_triangle.v0.x, 64'(1000 + exp_tag_q[0]));
          check("out_tri_y", out_triangle.v1.y, 64'(exp_tag_q[0] * 3));
          check("out_last", out_last, exp_last_q[0]);
          fd_exp = exp_last_q[0];
          void'(exp_tag_q.pop_front());
          void'(exp_last_q.pop_front());
          seen_out = 1'b1;
        end
      end
    end
  end

  task automatic queue_tri(input int tag, input bit last);
    in_item_t it;
    it.t = '0;
    it.t.v0.x = 16'(tag);
    it.t.v1.y = 16'(tag * 3);
    it.t.v2.z = 16'(tag + 7);
    it.last = last;
    send_q.push_back(it);
    exp_tag_q.push_back(tag);
    exp_last_q.push_back(last);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_tag_q.size() > 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < limit, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_triangle  = '0;
    in_transform = '0;
    lane_ready   = '1;
    lane_result_valid = '0;
    lane_result[0] = '0;
    lane_result[1] = '0;
    out_ready    = 1'b1;
    lat[0] = 3;
    lat[1] = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_lane_result_ready", lane_result_ready, 2'b11);
    check("rst_lane_valid", lane_valid, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Single frame, equal latencies
    lane_log.delete();
    seen_out = 0; gap = 0; fd_count = 0;
    for (int i = 0; i < 8; i++) queue_tri(i, i == 7);
    wait_drain(200);
    check("t1_gap", gap, 0);
    check("t1_frames", fd_count, 1);
    check("t1_lane_count", lane_log.size(), 8);
    for (int i = 0; i < 8; i++) check("t1_lane_order", lane_log[i], i % 2);

    // Slow lane 1
    lat[0] = 2; lat[1] = 10;
    seen_out = 0; gap = 0; fd_count = 0;
    for (int i = 0; i < 8; i++) queue_tri(i + 8, i == 7);
    wait_drain(300);
    check("t2_gap_seen", gap > 0, 1);
    check("t2_frames", fd_count, 1);

    // Output stall fills credits, then release
    lat[0] = 3; lat[1] = 3;
    fd_count = 0; accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) queue_tri(i + 20, i == 15);
    repeat (40) @(negedge clk);
    check("t3_accepted", accepted, 8);
    check("t3_in_ready", in_ready, 0);
    check("t3_busy", busy, 1);
    check("t3_out_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("t4_in_ready_full", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_in_ready_flow", in_ready, 1);
    end
    wait_drain(300);
    check("t3_accepted_all", accepted, 16);
    check("t3_frames", fd_count, 1);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) queue_tri(i + 50, i == 4);
    repeat (10) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_last", out_last, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_busy", busy, 0);
    check("t5_lane_result_ready", lane_result_ready, 2'b11);
    check("t5_lane_valid", lane_valid, 2'b00);
    send_q.delete();
    exp_tag_q.delete();
    exp_last_q.delete();
    lane_log.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    fd_count = 0;
    queue_tri(60, 1);
    @(posedge clk);
    #2;
    check("t5_first_lane_valid", lane_valid, 2'b01);
    wait_drain(100);
    check("t5_first_lane", (lane_log.size() > 0) ? lane_log[0] : 99, 0);
    check("t5_frames", fd_count, 1);

    // Back-to-back frames of 3 and 1
    fd_count = 0;
    queue_tri(70, 0);
    queue_tri(71, 0);
    queue_tri(72, 1);
    queue_tri(73, 1);
    wait_drain(100);
    check("t6_frames", fd_count, 2);
    check("t6_busy_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
